// File: rtl/converter_arbiter.sv
// Round-robin arbiter sharing one combinational converter among NREQ requesters.
// Define CONV_ARB_STATS_EN to add the served_cnt and busy status outputs.
module converter_arbiter #(
    parameter int NREQ  = 4,
    parameter int IN_W  = 4,
    parameter int OUT_W = 8,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*IN_W-1:0]   req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic [IN_W-1:0]        conv_in,
    input  logic [OUT_W-1:0]       conv_out,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [OUT_W-1:0]       rsp_data,
    input  logic                   rsp_ready
`ifdef CONV_ARB_STATS_EN
    ,
    output logic [15:0]            served_cnt,
    output logic                   busy
`endif
);

    typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IN_W-1:0]    conv_in_q, conv_in_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [OUT_W-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_valid_q, rsp_valid_d;

    logic               any_valid;
    logic [ID_W-1:0]    winner;
    logic [IN_W-1:0]    operand;

    // Scan offsets from farthest to nearest so the nearest valid requester wins.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int              idx;
            logic [NREQ-1:0] rot;
            idx = (int'(rr_ptr_q) + k) % NREQ;
            rot = req_valid >> idx;
            if (rot[0]) begin
                any_valid = 1'b1;
                winner    = ID_W'(idx);
            end
        end
    end

    // Only the granted lane is selected, so X on idle lanes never reaches conv_in.
    assign operand = IN_W'(req_data >> (int'(winner) * IN_W));

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = rst && (state_q == IDLE) && any_valid
                                   && (winner == ID_W'(gi));
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        conv_in_d   = conv_in_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    conv_in_d = operand;
                    rsp_id_d  = winner;
                    state_d   = CONV;
                end
            end
            CONV: begin
                rsp_data_d  = conv_out;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = (rsp_id_q == ID_W'(NREQ - 1)) ? '0 : rsp_id_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            conv_in_q   <= '0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            conv_in_q   <= conv_in_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign conv_in   = conv_in_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

`ifdef CONV_ARB_STATS_EN
    logic [15:0] served_q, served_d;

    always_comb begin
        served_d = served_q;
        if ((state_q == RESP) && rsp_ready && (served_q != 16'hFFFF))
            served_d = served_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) served_q <= '0;
        else      served_q <= served_d;
    end

    assign served_cnt = served_q;
    assign busy       = (state_q != IDLE);
`endif

endmodule

// File: tb/tb_converter_arbiter.sv
// Directed-vector bench for converter_arbiter with the {x, ~x} stub converter.
// Covers grant order, backpressure, wrap/skip, mid-op reset and optional stats.
module tb_converter_arbiter;

    localparam int NREQ = 4, IN_W = 4, OUT_W = 8, ID_W = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*IN_W-1:0] req_data = '0;
    logic [NREQ-1:0]      req_ready;
    logic [IN_W-1:0]      conv_in;
    logic [OUT_W-1:0]     conv_out;
    logic                 rsp_valid;
    logic [ID_W-1:0]      rsp_id;
    logic [OUT_W-1:0]     rsp_data;
    logic                 rsp_ready = 1'b0;
`ifdef CONV_ARB_STATS_EN
    logic [15:0]          served_cnt;
    logic                 busy;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign conv_out = {conv_in, ~conv_in};

    converter_arbiter #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .conv_in   (conv_in),
        .conv_out  (conv_out),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready)
`ifdef CONV_ARB_STATS_EN
        ,
        .served_cnt(served_cnt),
        .busy      (busy)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
    endtask

    // Runs one accept/convert/respond sequence from IDLE with rsp_ready=1.
    task automatic one_txn(input string tag, input logic [3:0] exp_rdy,
                           input logic [1:0] exp_id, input logic [7:0] exp_data);
        rsp_ready = 1'b1;
        #1;
        check({tag, ".req_ready"}, 32'(req_ready), 32'(exp_rdy));
        tick();
        check({tag, ".conv_valid0"}, 32'(rsp_valid), 32'd0);
        check({tag, ".conv_rdy0"}, 32'(req_ready), 32'd0);
        tick();
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, ".rsp_id"}, 32'(rsp_id), 32'(exp_id));
        check({tag, ".rsp_data"}, 32'(rsp_data), 32'(exp_data));
        tick();
        check({tag, ".idle_valid0"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic [3:0] xlane;
        logic [1:0] ids [5];
        logic [7:0] dats [5];
        ids  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        dats = '{8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h1E};

        do_reset();
        check("rst.req_ready", 32'(req_ready), 32'd0);
        check("rst.conv_in", 32'(conv_in), 32'd0);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_id", 32'(rsp_id), 32'd0);
        check("rst.rsp_data", 32'(rsp_data), 32'd0);

        // 1: single request
        req_valid = 4'b0001;
        req_data  = 16'h0003;
        rsp_ready = 1'b1;
        #1;
        check("t1.req_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        check("t1.conv_in", 32'(conv_in), 32'h3);
        check("t1.conv_valid0", 32'(rsp_valid), 32'd0);
        tick();
        check("t1.rsp_valid", 32'(rsp_valid), 32'd1);
        check("t1.rsp_id", 32'(rsp_id), 32'd0);
        check("t1.rsp_data", 32'(rsp_data), 32'h3C);
        tick();
        check("t1.idle_valid0", 32'(rsp_valid), 32'd0);

        // 2: all four requesting continuously
        do_reset();
        req_valid = 4'b1111;
        req_data  = 16'h4321;
        for (int i = 0; i < 5; i++)
            one_txn($sformatf("t2.g%0d", i), 4'(1 << ids[i]), ids[i], dats[i]);
        req_valid = 4'b0000;

        // 3: backpressure; ptr=1 so requester 2 wins, operand change must not leak
        req_valid = 4'b0100;
        req_data  = 16'h0500;
        rsp_ready = 1'b0;
        #1;
        check("t3.req_ready", 32'(req_ready), 32'h4);
        tick();
        req_data = 16'h0F00;
        tick();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t3.hold%0d.valid", k), 32'(rsp_valid), 32'd1);
            check($sformatf("t3.hold%0d.id", k), 32'(rsp_id), 32'd2);
            check($sformatf("t3.hold%0d.data", k), 32'(rsp_data), 32'h5A);
            check($sformatf("t3.hold%0d.rdy", k), 32'(req_ready), 32'd0);
            tick();
        end
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        #1;
        check("t3.last.valid", 32'(rsp_valid), 32'd1);
        tick();
        check("t3.done.valid", 32'(rsp_valid), 32'd0);

        // 4: wrap and skip from ptr=3; X on idle lanes 0 and 3
        xlane     = 4'bxxxx;
        req_valid = 4'b0110;
        req_data  = {xlane, 4'h7, 4'h6, xlane};
        one_txn("t4.a", 4'b0010, 2'd1, 8'h69);
        check("t4.a.conv_in", 32'(conv_in), 32'h6);
        one_txn("t4.b", 4'b0100, 2'd2, 8'h78);
        check("t4.b.conv_in", 32'(conv_in), 32'h7);
        req_valid = 4'b0000;

        // 5: reset while in CONV (ptr=3, requester 3 wins)
        req_valid = 4'b1000;
        req_data  = 16'h9000;
        #1;
        check("t5.req_ready", 32'(req_ready), 32'h8);
        tick();
        check("t5.conv_in", 32'(conv_in), 32'h9);
        rst = 1'b0;
        #1;
        check("t5.rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("t5.rst.conv_in", 32'(conv_in), 32'd0);
        check("t5.rst.req_ready", 32'(req_ready), 32'd0);
        tick();
        tick();
        check("t5.rst.hold_valid", 32'(rsp_valid), 32'd0);
        rst       = 1'b1;
        req_valid = 4'b1001;
        req_data  = 16'h9002;
        one_txn("t5.after", 4'b0001, 2'd0, 8'h2D);
        req_valid = 4'b0000;

`ifdef CONV_ARB_STATS_EN
        // 6: served counter and saturation
        do_reset();
        check("t6.cnt0", 32'(served_cnt), 32'd0);
        check("t6.busy0", 32'(busy), 32'd0);
        req_valid = 4'b0001;
        req_data  = 16'h0001;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) check("t6.busy1", 32'(busy), 32'd1);
            tick();
            tick();
        end
        req_valid = 4'b0000;
        #1;
        check("t6.cnt10", 32'(served_cnt), 32'd10);
        force dut.served_q = 16'hFFFE;
        #1;
        release dut.served_q;
        #1;
        check("t6.forced", 32'(served_cnt), 32'hFFFE);
        req_valid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            tick();
            tick();
        end
        req_valid = 4'b0000;
        #1;
        check("t6.sat", 32'(served_cnt), 32'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/converter_arbiter.md
Name: converter_arbiter

Overview:
Shares one combinational 4-bit to 8-bit converter instance between NREQ requesters.
- Round-robin arbitration.
- Registers the winner's operand onto the converter input.
- Samples the converter output one cycle later.
- Returns the result with requester ID over a valid/ready response channel.

Sits between requester logic and the converter datapath; the converter is instantiated at the same level and wired to conv_in/conv_out.

Parameters:
NREQ, 4, number of requesters (2..8)
IN_W, 4, converter input width
OUT_W, 8, converter output width
ID_W, 2, width of rsp_id; must satisfy 2**ID_W >= NREQ

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
req_valid  input  NREQ  per-requester request valid
req_data  input  NREQ*IN_W  packed operands; requester i uses bits [i*IN_W +: IN_W]
req_ready  output  NREQ  one-hot accept strobe
conv_in  output  IN_W  registered operand to shared converter
conv_out  input  OUT_W  converter result (combinational from conv_in)
rsp_valid  output  1  response valid
rsp_id  output  ID_W  index of requester owning the response
rsp_data  output  OUT_W  registered converter result
rsp_ready  input  1  consumer accepts response

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, rr_ptr=0, req_ready=0, conv_in=0, rsp_valid=0, rsp_id=0, rsp_data=0. Reset mid-transaction drops the in-flight request silently; no response is produced.
- FSM states: IDLE, CONV, RESP.
- IDLE:
  - If no req_valid bit is set, stay in IDLE.
  - Otherwise, winner = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready is combinational: req_ready[winner]=1 in IDLE only, all other bits 0. Handshake completes the same cycle.
  - On that edge: conv_in <= operand of winner, rsp_id <= winner, go to CONV.
- CONV (exactly 1 cycle, converter settle): rsp_data <= conv_out, rsp_valid <= 1, go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id and rsp_data stable until rsp_ready=1.
  - On the edge with rsp_valid & rsp_ready: rsp_valid <= 0, rr_ptr <= (rsp_id+1) mod NREQ, go to IDLE.
- req_ready is 0 in CONV and RESP.
- Latency: accept at cycle T gives rsp_valid high from cycle T+2.
- Throughput with rsp_ready held at 1: one response every 3 cycles.
- rr_ptr wraps from NREQ-1 to 0.
- A requester that deasserts req_valid before its grant is not served and causes no side effect.
- req_data changes after acceptance do not affect the in-flight result.
- conv_in holds its last value while idle.
- X on a req_data lane whose req_valid=0 must not propagate to conv_in.

Optional Feature:
CONV_ARB_STATS_EN
- Defined:
  - Adds output served_cnt[15:0], reset to 0.
  - Increments on every completed response handshake; saturates at 16'hFFFF.
  - Adds output busy (1 when state != IDLE).
- Undefined: neither port exists, and there is no counter logic.

Test Plan:
Stub converter for all scenarios: conv_out = {conv_in, ~conv_in}.
1. Single request: req_valid=4'b0001, requester 0 operand 4'h3, rsp_ready=1.
   Required: req_ready=4'b0001 at T; rsp_valid at T+2 with rsp_id=0, rsp_data=8'h3C; back in IDLE at T+3.
2. All four requesting continuously, operands 1, 2, 3, 4, rsp_ready=1.
   Required: grant order 0,1,2,3,0; rsp_data 8'h1E, 8'h2D, 8'h3C, 8'h4B; responses spaced 3 cycles.
3. Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises.
   Required: rsp_valid, rsp_id and rsp_data stable for 5 cycles; req_ready=0 throughout; completion on the first cycle rsp_ready=1.
4. Wrap and skip: rr_ptr=3, req_valid=4'b0110.
   Required: winner=1; next grant with the same requests goes to 2.
5. Reset mid-op: drop rst while in CONV.
   Required: rsp_valid=0 and conv_in=0 immediately (before the next edge); after release, a request on requester 0 is granted first.
6. With CONV_ARB_STATS_EN defined: 10 completed responses.
   Required: served_cnt=10. Force 16'hFFFE and complete 3 more; required served_cnt=16'hFFFF.
